dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr_arb2.sv | 20 ++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory arbiter: access codes carried on the
// *_rwe buses, the default data-memory depth, and a small decode helper.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DMEM_DEPTH = 64;

    localparam logic [1:0] RWE_LOAD = 2'd0;
    localparam logic [1:0] RWE_SB   = 2'd1;
    localparam logic [1:0] RWE_SH   = 2'd2;
    localparam logic [1:0] RWE_SW   = 2'd3;

    // True for any access code that writes memory.
    function automatic logic is_store(input logic [1:0] rwe);
        return (rwe == RWE_SB) || (rwe == RWE_SH) || (rwe == RWE_SW);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin pick. With a single requester that requester wins; with
// both requesting, the port that was not granted most recently wins.
//
// Ports:
//   req[1:0]  in   request vector (bit i = port i)
//   last      in   index of the most recently granted port
//   gnt[1:0]  out  grant vector, one-hot or zero
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] |  last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port data memory between requester 0 (core load/store)
// and requester 1 (debug/loader). Grant is combinational, so a lone request is
// served in the cycle it appears; ties alternate round-robin. Every transfer
// gets a one-cycle response (rvalid) the cycle after the grant, carrying the
// memory read data sampled on the transfer edge (pre-store contents for
// stores).
//
// Configuration macro:
//   DMEM_ARB_RANGE_CHECK_EN  when defined, a granted access with addr >= DEPTH
//                            is suppressed at the memory (no store) and
//                            answered with err = 1, rdata = 0. When undefined,
//                            addresses pass through and err is always 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   m0_req/addr/wdata/rwe     requester 0 request fields (in)
//   m0_gnt                    requester 0 accepted this cycle (out)
//   m0_rvalid/rdata/err       requester 0 response (out)
//   m1_*                      requester 1, same as m0_*
//   mem_a, mem_wd, mem_rwe    address, store data, access code to memory (out)
//   mem_rd                    combinational read data from memory (in)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic [DW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [1:0]    m0_rwe,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic [DW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [1:0]    m1_rwe,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_err,

    output logic [DW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    output logic [1:0]    mem_rwe,
    input  logic [DW-1:0] mem_rd
);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic [1:0]    req;
    logic [1:0]    gnt_raw;
    logic [1:0]    gnt;
    logic          last;

    logic [DW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [1:0]    g_rwe;
    logic          oor;

    logic [1:0]    vld_p1;
    logic [1:0]    err_p1;
    logic [DW-1:0] rdata0_p1;
    logic [DW-1:0] rdata1_p1;

    assign req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req  (req),
        .last (last),
        .gnt  (gnt_raw)
    );

    // Grants are blocked while in reset so nothing reaches memory.
    assign gnt    = rst ? 2'b00 : gnt_raw;
    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    // Memory-side mux; idle cycles park on m0's address with a load code.
    always_comb begin
        g_addr  = m0_addr;
        g_wdata = m0_wdata;
        g_rwe   = RWE_LOAD;
        if (gnt[1]) begin
            g_addr  = m1_addr;
            g_wdata = m1_wdata;
            g_rwe   = m1_rwe;
        end else if (gnt[0]) begin
            g_addr  = m0_addr;
            g_wdata = m0_wdata;
            g_rwe   = m0_rwe;
        end
    end

    // Folds to 0 when range checking is compiled out.
    assign oor = RANGE_CHECK && (g_addr >= DW'(DEPTH));

    assign mem_a   = g_addr;
    assign mem_wd  = g_wdata;
    assign mem_rwe = (oor && is_store(g_rwe)) ? RWE_LOAD : g_rwe;

    // ---- stage p0 -> p1: transfer edge, capture response ----
    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            vld_p1    <= 2'b00;
            err_p1    <= 2'b00;
            rdata0_p1 <= '0;
            rdata1_p1 <= '0;
        end else begin
            vld_p1 <= gnt;
            err_p1 <= gnt & {2{oor}};
            if (|gnt) begin
                last <= gnt[1];
            end
            if (gnt[0]) begin
                rdata0_p1 <= oor ? '0 : mem_rd;
            end
            if (gnt[1]) begin
                rdata1_p1 <= oor ? '0 : mem_rd;
            end
        end
    end

    // A response due in a cycle where rst has risen is discarded.
    assign m0_rvalid = vld_p1[0] & ~rst;
    assign m1_rvalid = vld_p1[1] & ~rst;
    assign m0_err    = err_p1[0] & ~rst;
    assign m1_err    = err_p1[1] & ~rst;
    assign m0_rdata  = rdata0_p1;
    assign m1_rdata  = rdata1_p1;

endmodule
